// File: rtl/bitser_tx.sv
// Bit-serial operand transmitter: loads an operand pair and streams it LSB-first, one bit of each per beat.
// Optional macro BITSER_TX_SUM_EN adds a running serial sum (ser_sum) and carry-out (ser_cout).
module bitser_tx #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             ser_a,
    output logic             ser_b,
    output logic             ser_last,
`ifdef BITSER_TX_SUM_EN
    output logic             ser_sum,
    output logic             ser_cout,
`endif
    output logic             busy
);

    // Handshakes (both ports): a transfer happens on a rising edge where valid & ready are both 1;
    // a valid source holds its data stable until that edge.

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_PENULT = CW'(WIDTH - 2);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_sh_a;
    logic [WIDTH-1:0] r_sh_b;
    logic [CW-1:0]    r_cnt;
    logic             r_valid;
    logic             r_last;

    logic w_beat;
    logic w_load;

    assign w_beat   = r_valid & ser_ready;
    assign in_ready = (r_state == S_IDLE) | (r_last & ser_ready);
    assign w_load   = in_valid & in_ready;

    assign ser_valid = r_valid;
    assign ser_a     = r_sh_a[0];
    assign ser_b     = r_sh_b[0];
    assign ser_last  = r_last;
    assign busy      = (r_state == S_SHIFT);

    // A load always wins: at the last beat it overwrites the shifted regs so the next beat is bit 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_sh_a  <= '0;
            r_sh_b  <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else if (w_load) begin
            r_state <= S_SHIFT;
            r_sh_a  <= in_a;
            r_sh_b  <= in_b;
            r_cnt   <= '0;
            r_valid <= 1'b1;
            r_last  <= 1'b0;
        end else if (w_beat) begin
            r_sh_a <= {1'b0, r_sh_a[WIDTH-1:1]};
            r_sh_b <= {1'b0, r_sh_b[WIDTH-1:1]};
            if (r_last) begin
                r_state <= S_IDLE;
                r_cnt   <= '0;
                r_valid <= 1'b0;
                r_last  <= 1'b0;
            end else begin
                r_cnt  <= r_cnt + CW'(1);
                r_last <= (r_cnt == CNT_PENULT);
            end
        end
    end

`ifdef BITSER_TX_SUM_EN
    logic r_carry;
    logic w_cout;

    assign w_cout   = (r_sh_a[0] & r_sh_b[0]) | (r_carry & (r_sh_a[0] ^ r_sh_b[0]));
    assign ser_sum  = r_sh_a[0] ^ r_sh_b[0] ^ r_carry;
    assign ser_cout = w_cout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_carry <= 1'b0;
        end else if (w_load) begin
            r_carry <= 1'b0;
        end else if (w_beat) begin
            r_carry <= w_cout;
        end
    end
`endif

endmodule

// File: tb/tb_bitser_tx.sv
// Self-checking bench for bitser_tx: directed scenarios plus randomized traffic against a beat-queue model.
module tb_bitser_tx;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         ser_valid;
    logic         ser_ready = 1'b0;
    logic         ser_a;
    logic         ser_b;
    logic         ser_last;
    logic         busy;
`ifdef BITSER_TX_SUM_EN
    logic         ser_sum;
    logic         ser_cout;
`endif

    bitser_tx #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .ser_valid (ser_valid),
        .ser_ready (ser_ready),
        .ser_a     (ser_a),
        .ser_b     (ser_b),
        .ser_last  (ser_last),
`ifdef BITSER_TX_SUM_EN
        .ser_sum   (ser_sum),
        .ser_cout  (ser_cout),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Each entry is one expected beat: {a, b, last, sum, cout}
    logic [4:0] exp_q[$];
    int         load_cnt = 0;
    logic       m_rdy;

    task automatic push_frame(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        for (int i = 0; i < W; i++)
            exp_q.push_back({a[i], b[i], (i == W - 1), s[i], s[W]});
    endtask

    // Model update: consume a beat on acceptance, append a whole frame on an operand handshake.
    always @(posedge clk) begin
        if (!rst) begin
            m_rdy = (exp_q.size() == 0) || (exp_q[0][2] && ser_ready);
            if (exp_q.size() != 0 && ser_ready) void'(exp_q.pop_front());
            if (in_valid && m_rdy) begin
                push_frame(in_a, in_b);
                load_cnt++;
            end
        end
    end

    // Per-cycle comparison of all outputs against the model head.
    always @(negedge clk) begin
        if (!rst) begin
            check("ser_valid", 32'(ser_valid), 32'(exp_q.size() != 0));
            check("busy", 32'(busy), 32'(exp_q.size() != 0));
            check("in_ready", 32'(in_ready),
                  32'((exp_q.size() == 0) || (exp_q[0][2] && ser_ready)));
            if (exp_q.size() != 0) begin
                check("ser_a", 32'(ser_a), 32'(exp_q[0][4]));
                check("ser_b", 32'(ser_b), 32'(exp_q[0][3]));
                check("ser_last", 32'(ser_last), 32'(exp_q[0][2]));
`ifdef BITSER_TX_SUM_EN
                check("ser_sum", 32'(ser_sum), 32'(exp_q[0][1]));
                if (exp_q[0][2]) check("ser_cout", 32'(ser_cout), 32'(exp_q[0][0]));
`endif
            end else begin
                check("idle_last", 32'(ser_last), 32'(0));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_load(input bit rand_rdy, output int ticks);
        int start;
        start = load_cnt;
        ticks = 0;
        while (load_cnt == start && ticks < 200) begin
            if (rand_rdy) ser_ready = ($urandom_range(0, 3) != 0);
            tick();
            ticks++;
        end
        check("load_timeout", 32'(load_cnt != start), 32'(1));
    endtask

    // Counts cycles with busy high, driving ser_ready from pat (1 beyond its length).
    task automatic run_busy(input logic [15:0] pat, input int plen, output int n);
        n = 0;
        while (busy && n < 200) begin
            ser_ready = (n < plen) ? pat[n] : 1'b1;
            tick();
            n++;
        end
        ser_ready = 1'b1;
    endtask

    task automatic start_frame(input logic [W-1:0] a, input logic [W-1:0] b);
        int t;
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        wait_load(1'b0, t);
        in_valid = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int t;
        logic [15:0] pat;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_in_ready", 32'(in_ready), 32'(1));
        check("rst_ser_valid", 32'(ser_valid), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_ser_last", 32'(ser_last), 32'(0));
        check("rst_ser_a", 32'(ser_a), 32'(0));
        check("rst_ser_b", 32'(ser_b), 32'(0));
        ser_ready = 1'b1;
        tick();

        // Single frame, continuous ready
        start_frame(8'hA5, 8'h3C);
        check("single_in_ready_drop", 32'(in_ready), 32'(0));
        run_busy(16'hFFFF, 16, n);
        check("single_busy_cycles", 32'(n), 32'(8));
        tick();

        // Backpressure: stalls of 2 cycles before beats 3 and 6
        start_frame(8'hA5, 8'h3C);
        pat = 16'b1111_1110_0111_0011;
        run_busy(pat, 12, n);
        check("bp_busy_cycles", 32'(n), 32'(12));
        tick();

        // Back-to-back frames with in_valid held
        in_a = 8'hFF; in_b = 8'h01; in_valid = 1'b1;
        wait_load(1'b0, t);
        in_a = 8'h00; in_b = 8'hFF;
        wait_load(1'b0, t);
        check("b2b_gap_ticks", 32'(t), 32'(8));
        in_valid = 1'b0;
        run_busy(16'hFFFF, 16, n);
        check("b2b_second_busy", 32'(n), 32'(8));
        tick();

        // Reset in the middle of a frame
        start_frame(8'hA5, 8'h3C);
        tick(); tick(); tick();
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("mid_rst_valid", 32'(ser_valid), 32'(0));
        check("mid_rst_busy", 32'(busy), 32'(0));
        check("mid_rst_last", 32'(ser_last), 32'(0));
        tick();
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'(1));
        tick();
        start_frame(8'h12, 8'h34);
        run_busy(16'hFFFF, 16, n);
        check("post_rst_busy", 32'(n), 32'(8));
        tick();

        // Sum-oriented operand pairs (checked per beat by the model when the sum outputs exist)
        start_frame(8'hFF, 8'h01);
        run_busy(16'hFFFF, 16, n);
        start_frame(8'h5A, 8'h25);
        run_busy(16'hFFFF, 16, n);
        start_frame(8'h01, 8'h01);
        run_busy(16'hFFFF, 16, n);
        check("sum_frame_busy", 32'(n), 32'(8));
        tick();

        // Randomized traffic: random operands, random valid, random backpressure
        for (int c = 0; c < 2000; c++) begin
            ser_ready = ($urandom_range(0, 3) != 0);
            in_valid  = ($urandom_range(0, 2) != 0);
            in_a      = W'($urandom);
            in_b      = W'($urandom);
            tick();
        end
        in_valid  = 1'b0;
        ser_ready = 1'b1;
        run_busy(16'hFFFF, 16, n);
        check("drain_idle", 32'(busy), 32'(0));
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/bitser_tx.md
Name: bitser_tx

Overview:
- Bit-serial operand transmitter; the source end of a serial-add link.
- Accepts two WIDTH-bit operands on a valid/ready port and shifts them out LSB-first, one bit of each per beat, to a downstream bit-serial consumer (serial adder or black-box sink).
- Uses a ser_valid/ser_ready beat handshake and marks the final beat with ser_last.

Parameters:
- WIDTH, 8, operand width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  block can accept operand pair this cycle
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B
- ser_valid  output  1  serial beat valid
- ser_ready  input  1  consumer accepts beat
- ser_a  output  1  current bit of A
- ser_b  output  1  current bit of B
- ser_last  output  1  current beat is bit WIDTH-1
- busy  output  1  frame in progress (state SHIFT)

Behaviour:
- Reset (async, rst=1), all registers cleared immediately:
  - state=IDLE
  - ser_valid=0, ser_a=0, ser_b=0, ser_last=0, busy=0
  - bit counter=0, shift registers=0
  - in_ready is combinational; it is 1 in IDLE after reset.
- State IDLE:
  - in_ready=1, ser_valid=0.
  - On in_valid&in_ready at edge N: load in_a/in_b into shift regs and clear the counter.
  - State=SHIFT from edge N, so ser_valid=1 in cycle N+1 with ser_a=in_a[0], ser_b=in_b[0].
  - Load-to-first-beat latency is 1 cycle.
- State SHIFT:
  - ser_valid=1, busy=1.
  - ser_a/ser_b are the shift-register LSBs, always registered (no comb path from in_* to ser_*).
  - Beat handshake: the beat completes only when ser_valid&ser_ready at an edge. Then shift both regs right by 1 and increment the counter.
  - When ser_ready=0: ser_a, ser_b, ser_last and the counter hold stable. Data must not change while valid and unaccepted.
  - ser_last=1 exactly when counter==WIDTH-1.
- in_ready in SHIFT = ser_last & ser_ready (combinational).
- End of frame, at the last beat handshake:
  - If in_valid=1 at the same edge: load the new pair, clear the counter, stay in SHIFT. The next beat is the new bit 0, giving back-to-back frames with no bubble.
  - Otherwise: go to IDLE; ser_valid=0 the next cycle.
- in_valid in SHIFT outside the last-beat handshake is ignored (in_ready=0); the operand is not consumed.
- Counter width is clog2(WIDTH); it never wraps past WIDTH-1 because the frame ends there.
- Reset mid-frame: the partial frame is dropped and outputs go to reset values asynchronously. After rst deasserts, the first frame starts from a fresh load.
- No X propagation: the shift-in bit is 0.

Optional Feature:
- Macro: BITSER_TX_SUM_EN.
- Defined:
  - Adds outputs ser_sum (1) and ser_cout (1), plus a carry register cleared on reset and at every load.
  - ser_sum = ser_a ^ ser_b ^ carry (combinational from registered values), valid with ser_valid.
  - On each beat handshake: carry <= majority(ser_a, ser_b, carry).
  - ser_cout = carry-out of the current beat (combinational); meaningful only when ser_last=1.
  - The concatenation {ser_cout on last beat, ser_sum beats} equals in_a+in_b as a (WIDTH+1)-bit result.
- Undefined: the ports and carry logic are absent; behaviour is otherwise identical.

Test Plan:
- Single frame, WIDTH=8, in_a=8'hA5, in_b=8'h3C, ser_ready=1:
  - in_ready drops the cycle after load.
  - ser_a sequence 1,0,1,0,0,1,0,1; ser_b sequence 0,0,1,1,1,1,0,0.
  - ser_last only on beat 8; busy high for 8 cycles, then IDLE.
- Backpressure: same operands, ser_ready=0 on beats 3 and 6 for 2 cycles each:
  - outputs hold during stalls; frame completes in 12 cycles; bit sequence unchanged.
- Back-to-back: in_valid held with 8'hFF/8'h01, then 8'h00/8'hFF:
  - second frame's bit 0 appears the cycle after the first's ser_last handshake; zero idle cycles between frames.
- Reset mid-frame: assert rst for 1 cycle at beat 4:
  - ser_valid, busy and ser_last drop immediately; in_ready=1 after deassert.
  - Next load of 8'h12/8'h34 streams correctly from bit 0.
- BITSER_TX_SUM_EN, in_a=8'hFF, in_b=8'h01:
  - ser_sum beats are all 0; ser_cout=1 on the last beat (sum 9'h100).
- BITSER_TX_SUM_EN, 8'h5A+8'h25 (9'h07F):
  - ser_sum LSB-first 1,1,1,1,1,1,1,0; ser_cout=0.
  - Carry is cleared on the next load.
